// File: rtl/axis_egress_if.sv
// AXI4-Stream bundle shared by the upstream and downstream sides of the egress stage.
interface axis_egress_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned USER_WIDTH = 1
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [USER_WIDTH-1:0] tuser;

    modport master (
        output tdata, tvalid, tlast, tuser,
        input  tready
    );

    modport slave (
        input  tdata, tvalid, tlast, tuser,
        output tready
    );
endinterface

// File: rtl/axis_egress.sv
// Zero-latency AXIS egress pass-through with saturating statistics,
// frame tracking and a sticky stability (protocol) monitor.
module axis_egress #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned USER_WIDTH = 1,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clr_stats,
    axis_egress_if.slave         s_axis,
    axis_egress_if.master        m_axis,
    output logic [CNT_WIDTH-1:0] o_beat_count,
    output logic [CNT_WIDTH-1:0] o_frame_count,
    output logic [CNT_WIDTH-1:0] o_err_count,
    output logic [CNT_WIDTH-1:0] o_stall_count,
    output logic                 o_proto_err,
    output logic                 o_in_frame
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_m_tvalid;
    logic                  w_xfer;
    logic                  w_stall;
    logic                  w_frame_end;
    logic                  w_err_end;
    logic                  w_violation;
    logic                  r_pend;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_last;
    logic [USER_WIDTH-1:0] r_user;
    logic [CNT_WIDTH-1:0]  r_beat_count;
    logic [CNT_WIDTH-1:0]  r_frame_count;
    logic [CNT_WIDTH-1:0]  r_err_count;
    logic [CNT_WIDTH-1:0]  r_stall_count;
    logic                  r_proto_err;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                      input logic               en);
        return (en && (v != '1)) ? v + CNT_WIDTH'(1) : v;
    endfunction

    // Datapath: straight wires, reset only gates the handshake
    assign w_m_tvalid      = s_axis.tvalid & ~i_rst;
    assign m_axis.tvalid   = w_m_tvalid;
    assign m_axis.tdata    = s_axis.tdata;
    assign m_axis.tlast    = s_axis.tlast;
    assign m_axis.tuser    = s_axis.tuser;
    assign s_axis.tready   = m_axis.tready & ~i_rst;

    assign w_xfer      = w_m_tvalid & m_axis.tready;
    assign w_stall     = w_m_tvalid & ~m_axis.tready;
    assign w_frame_end = w_xfer & s_axis.tlast;
    assign w_err_end   = w_frame_end & s_axis.tuser[0];

    // A stalled beat must reappear unchanged on the very next cycle
    assign w_violation = r_pend & (~w_m_tvalid
                                   | (s_axis.tdata != r_data)
                                   | (s_axis.tlast != r_last)
                                   | (s_axis.tuser != r_user));

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr_stats) begin
            r_beat_count  <= '0;
            r_frame_count <= '0;
            r_err_count   <= '0;
            r_stall_count <= '0;
            r_proto_err   <= 1'b0;
        end else begin
            r_beat_count  <= sat_inc(r_beat_count, w_xfer);
            r_frame_count <= sat_inc(r_frame_count, w_frame_end);
            r_err_count   <= sat_inc(r_err_count, w_err_end);
            r_stall_count <= sat_inc(r_stall_count, w_stall);
            if (w_violation) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pend <= 1'b0;
            r_data <= '0;
            r_last <= 1'b0;
            r_user <= '0;
        end else begin
            r_pend <= w_stall;
            r_data <= s_axis.tdata;
            r_last <= s_axis.tlast;
            r_user <= s_axis.tuser;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_xfer && !s_axis.tlast) w_state_nxt = ST_FRAME;
            ST_FRAME: if (w_frame_end)             w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    assign o_beat_count  = r_beat_count;
    assign o_frame_count = r_frame_count;
    assign o_err_count   = r_err_count;
    assign o_stall_count = r_stall_count;
    assign o_proto_err   = r_proto_err;
    assign o_in_frame    = (r_state == ST_FRAME);

endmodule

// File: tb/tb_axis_egress.sv
// Directed vector bench for axis_egress: handshake, statistics, frame tracking,
// protocol monitor, clear/reset priority and counter saturation.
module tb_axis_egress;

    logic clk;
    logic rst;
    logic clr;
    logic clr2;

    axis_egress_if #(.DATA_WIDTH(8), .USER_WIDTH(1)) s_if ();
    axis_egress_if #(.DATA_WIDTH(8), .USER_WIDTH(1)) m_if ();
    axis_egress_if #(.DATA_WIDTH(8), .USER_WIDTH(1)) s2_if ();
    axis_egress_if #(.DATA_WIDTH(8), .USER_WIDTH(1)) m2_if ();

    logic [31:0] beat_count, frame_count, err_count, stall_count;
    logic        proto_err, in_frame;
    logic [3:0]  beat2, frame2, err2, stall2;
    logic        proto2, in_frame2;

    axis_egress #(.DATA_WIDTH(8), .USER_WIDTH(1), .CNT_WIDTH(32)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_clr_stats  (clr),
        .s_axis       (s_if),
        .m_axis       (m_if),
        .o_beat_count (beat_count),
        .o_frame_count(frame_count),
        .o_err_count  (err_count),
        .o_stall_count(stall_count),
        .o_proto_err  (proto_err),
        .o_in_frame   (in_frame)
    );

    axis_egress #(.DATA_WIDTH(8), .USER_WIDTH(1), .CNT_WIDTH(4)) dut_sat (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_clr_stats  (clr2),
        .s_axis       (s2_if),
        .m_axis       (m2_if),
        .o_beat_count (beat2),
        .o_frame_count(frame2),
        .o_err_count  (err2),
        .o_stall_count(stall2),
        .o_proto_err  (proto2),
        .o_in_frame   (in_frame2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, clr, tv, tr, last, user;
        logic [7:0]  d;
        logic        e_mv, e_sr;
        logic [31:0] e_b, e_f, e_e, e_s;
        logic        e_p, e_i;
    } vec_t;

    vec_t vq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic c, input logic tv, input logic tr,
                       input logic [7:0] d, input logic last, input logic user,
                       input logic mv, input logic sr,
                       input int b, input int f, input int e, input int s,
                       input logic p, input logic i);
        vec_t v;
        v.rst = r; v.clr = c; v.tv = tv; v.tr = tr; v.d = d; v.last = last; v.user = user;
        v.e_mv = mv; v.e_sr = sr;
        v.e_b = 32'(b); v.e_f = 32'(f); v.e_e = 32'(e); v.e_s = 32'(s);
        v.e_p = p; v.e_i = i;
        vq.push_back(v);
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; clr2 = 1'b0;
        s_if.tvalid = 1'b0; s_if.tdata = 8'h00; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
        m_if.tready = 1'b0;
        s2_if.tvalid = 1'b0; s2_if.tdata = 8'h00; s2_if.tlast = 1'b0; s2_if.tuser = 1'b0;
        m2_if.tready = 1'b0;

        //  rst clr tv tr  data  lst usr  mv sr  beat frm err stl prt infr
        add(1, 0, 1, 1, 8'h00, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0);  // reset with traffic
        add(0, 0, 1, 0, 8'hBE, 1, 0,  1, 0,  0, 0, 0, 1, 0, 0);  // backpressure
        add(0, 0, 1, 1, 8'hBE, 1, 0,  1, 1,  1, 1, 0, 1, 0, 0);  // release
        add(0, 1, 0, 1, 8'h00, 0, 0,  0, 1,  0, 0, 0, 0, 0, 0);  // clear
        add(0, 0, 1, 1, 8'h01, 0, 0,  1, 1,  1, 0, 0, 0, 0, 1);  // 4-beat frame
        add(0, 0, 1, 1, 8'h02, 0, 0,  1, 1,  2, 0, 0, 0, 0, 1);
        add(0, 0, 1, 1, 8'h03, 0, 0,  1, 1,  3, 0, 0, 0, 0, 1);
        add(0, 0, 1, 1, 8'h04, 1, 1,  1, 1,  4, 1, 1, 0, 0, 0);
        add(0, 0, 1, 0, 8'hAA, 0, 0,  1, 0,  4, 1, 1, 1, 0, 0);  // stall AA
        add(0, 0, 1, 0, 8'h55, 0, 0,  1, 0,  4, 1, 1, 2, 1, 0);  // data changed
        add(0, 0, 1, 0, 8'h55, 0, 0,  1, 0,  4, 1, 1, 3, 1, 0);  // sticky
        add(0, 0, 0, 1, 8'h55, 0, 0,  0, 1,  4, 1, 1, 3, 1, 0);
        add(0, 1, 0, 1, 8'h00, 0, 0,  0, 1,  0, 0, 0, 0, 0, 0);  // clear
        add(0, 1, 1, 1, 8'h11, 0, 0,  1, 1,  0, 0, 0, 0, 0, 1);  // clr beats xfer, not in_frame
        add(0, 0, 1, 1, 8'h12, 0, 0,  1, 1,  1, 0, 0, 0, 0, 1);
        add(1, 0, 1, 1, 8'h13, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0);  // rst mid-frame
        add(0, 0, 1, 1, 8'h21, 1, 0,  1, 1,  1, 1, 0, 0, 0, 0);  // single-beat frame
        add(0, 0, 1, 0, 8'h33, 1, 0,  1, 0,  1, 1, 0, 1, 0, 0);  // stall
        add(0, 0, 0, 0, 8'h33, 1, 0,  0, 0,  1, 1, 0, 1, 1, 0);  // valid withdrawn
        add(0, 1, 0, 0, 8'h00, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 8'h44, 0, 0,  1, 0,  0, 0, 0, 1, 0, 0);  // stall
        add(0, 0, 1, 0, 8'h44, 1, 0,  1, 0,  0, 0, 0, 2, 1, 0);  // tlast changed
        add(0, 1, 1, 1, 8'h44, 1, 0,  1, 1,  0, 0, 0, 0, 0, 0);  // clr beats xfer

        foreach (vq[k]) begin
            @(negedge clk);
            rst = vq[k].rst; clr = vq[k].clr;
            s_if.tvalid = vq[k].tv; s_if.tdata = vq[k].d;
            s_if.tlast = vq[k].last; s_if.tuser = vq[k].user;
            m_if.tready = vq[k].tr;
            #1;
            chk("m_tvalid", k, 32'(m_if.tvalid), 32'(vq[k].e_mv));
            chk("s_tready", k, 32'(s_if.tready), 32'(vq[k].e_sr));
            chk("m_tdata",  k, 32'(m_if.tdata),  32'(vq[k].d));
            chk("m_tlast",  k, 32'(m_if.tlast),  32'(vq[k].last));
            @(posedge clk);
            #1;
            chk("beat_count",  k, beat_count,  vq[k].e_b);
            chk("frame_count", k, frame_count, vq[k].e_f);
            chk("err_count",   k, err_count,   vq[k].e_e);
            chk("stall_count", k, stall_count, vq[k].e_s);
            chk("proto_err",   k, 32'(proto_err), 32'(vq[k].e_p));
            chk("in_frame",    k, 32'(in_frame),  32'(vq[k].e_i));
        end

        // Saturation on a 4-bit counter instance
        chk("sat_start", 0, 32'(beat2), 32'd0);
        @(negedge clk);
        s2_if.tvalid = 1'b1; s2_if.tlast = 1'b1; m2_if.tready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s2_if.tdata = 8'(i);
            @(posedge clk);
            #1;
            chk("sat_beat",  i, 32'(beat2),  (i + 1 > 15) ? 32'd15 : 32'(i + 1));
            chk("sat_frame", i, 32'(frame2), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
        end
        @(negedge clk);
        s2_if.tvalid = 1'b0; m2_if.tready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
